// File: rtl/bin_morph_3x3_if.sv
// Stream bundle for the binary 3x3 morphology engine: the incoming window from the
// matrix generator, the processed 1-bit stream and the per-frame foreground statistics.
interface bin_morph_3x3_if #(
  parameter int CNT_W = 20
);
  logic             matrix_img_vsync;
  logic             matrix_img_href;
  logic             matrix_top_edge_flag;
  logic             matrix_bottom_edge_flag;
  logic             matrix_left_edge_flag;
  logic             matrix_right_edge_flag;
  logic             matrix_p11, matrix_p12, matrix_p13;
  logic             matrix_p21, matrix_p22, matrix_p23;
  logic             matrix_p31, matrix_p32, matrix_p33;
  logic             post_img_vsync;
  logic             post_img_href;
  logic             post_img_bit;
  logic [CNT_W-1:0] frame_fg_count;
  logic             frame_done;

  modport slave (
    input  matrix_img_vsync, matrix_img_href,
    input  matrix_top_edge_flag, matrix_bottom_edge_flag,
    input  matrix_left_edge_flag, matrix_right_edge_flag,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    output post_img_vsync, post_img_href, post_img_bit,
    output frame_fg_count, frame_done
  );

  modport master (
    output matrix_img_vsync, matrix_img_href,
    output matrix_top_edge_flag, matrix_bottom_edge_flag,
    output matrix_left_edge_flag, matrix_right_edge_flag,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    input  post_img_vsync, post_img_href, post_img_bit,
    input  frame_fg_count, frame_done
  );
endinterface

// File: rtl/bin_morph_3x3.sv
// Binary 3x3 erode/dilate/boundary engine with frame-latched mode and pad value,
// 2-cycle latency, and a saturating per-frame foreground pixel counter.
module bin_morph_3x3 #(
  parameter int CNT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_pad,
  bin_morph_3x3_if.slave    io
);

  function automatic logic morph_sel(input logic [1:0] mode, input logic centre,
                                     input logic erode, input logic dilate);
    case (mode)
      2'b01:   return erode;
      2'b10:   return dilate;
      2'b11:   return centre & ~erode;
      default: return centre;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
    if (inc && (a != '1)) return a + CNT_W'(1);
    return a;
  endfunction

  logic             vsync_q, vsync_d;
  logic             armed_q, armed_d;
  logic             in_frame_q, in_frame_d;
  logic [1:0]       mode_q, mode_d;
  logic             pad_q, pad_d;
  logic             vsync_p1_q, vsync_p1_d;
  logic             href_p1_q, href_p1_d;
  logic             bit_p1_q, bit_p1_d;
  logic             vsync_p2_q, vsync_p2_d;
  logic             href_p2_q, href_p2_d;
  logic             bit_p2_q, bit_p2_d;
  logic             post_vs_q, post_vs_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             vsync_rise, live;
  logic [1:0]       mode_eff;
  logic             pad_eff;
  logic [8:0]       tap;
  logic             post_rise, post_fall;

  // Input stage: frame latch and padded window. armed_q blocks a false rise when
  // reset is released in the middle of a frame.
  always_comb begin
    vsync_rise = io.matrix_img_vsync & ~vsync_q & armed_q;
    live       = vsync_rise | in_frame_q;
    mode_eff   = vsync_rise ? cfg_mode : mode_q;
    pad_eff    = vsync_rise ? cfg_pad  : pad_q;

    vsync_d    = io.matrix_img_vsync;
    armed_d    = armed_q | ~io.matrix_img_vsync;
    mode_d     = mode_eff;
    pad_d      = pad_eff;
    in_frame_d = io.matrix_img_vsync & live;

    tap[0] = (io.matrix_top_edge_flag    | io.matrix_left_edge_flag)  ? pad_eff : io.matrix_p11;
    tap[1] =  io.matrix_top_edge_flag                                 ? pad_eff : io.matrix_p12;
    tap[2] = (io.matrix_top_edge_flag    | io.matrix_right_edge_flag) ? pad_eff : io.matrix_p13;
    tap[3] =  io.matrix_left_edge_flag                                ? pad_eff : io.matrix_p21;
    tap[4] =  io.matrix_p22;
    tap[5] =  io.matrix_right_edge_flag                               ? pad_eff : io.matrix_p23;
    tap[6] = (io.matrix_bottom_edge_flag | io.matrix_left_edge_flag)  ? pad_eff : io.matrix_p31;
    tap[7] =  io.matrix_bottom_edge_flag                              ? pad_eff : io.matrix_p32;
    tap[8] = (io.matrix_bottom_edge_flag | io.matrix_right_edge_flag) ? pad_eff : io.matrix_p33;

    vsync_p1_d = io.matrix_img_vsync & live;
    href_p1_d  = io.matrix_img_href  & live;
    bit_p1_d   = morph_sel(mode_eff, io.matrix_p22, &tap, |tap);
  end

  // Stage 1 -> stage 2: output register, pixel masked outside href.
  always_comb begin
    vsync_p2_d = vsync_p1_q;
    href_p2_d  = href_p1_q;
    bit_p2_d   = bit_p1_q & href_p1_q;
  end

  // Stage 2: foreground statistics on the emitted stream.
  always_comb begin
    post_rise = vsync_p2_q & ~post_vs_q;
    post_fall = ~vsync_p2_q & post_vs_q;
    post_vs_d = vsync_p2_q;
    acc_d     = sat_inc(post_rise ? '0 : acc_q, href_p2_q & bit_p2_q);
    active_d  = active_q;
    if (post_rise)      active_d = 1'b1;
    else if (post_fall) active_d = 1'b0;
    done_d    = post_fall & active_q;
    cnt_d     = done_d ? acc_q : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      armed_q    <= 1'b0;
      in_frame_q <= 1'b0;
      mode_q     <= 2'b00;
      pad_q      <= 1'b0;
      vsync_p1_q <= 1'b0;
      href_p1_q  <= 1'b0;
      bit_p1_q   <= 1'b0;
      vsync_p2_q <= 1'b0;
      href_p2_q  <= 1'b0;
      bit_p2_q   <= 1'b0;
      post_vs_q  <= 1'b0;
      active_q   <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      vsync_q    <= vsync_d;
      armed_q    <= armed_d;
      in_frame_q <= in_frame_d;
      mode_q     <= mode_d;
      pad_q      <= pad_d;
      vsync_p1_q <= vsync_p1_d;
      href_p1_q  <= href_p1_d;
      bit_p1_q   <= bit_p1_d;
      vsync_p2_q <= vsync_p2_d;
      href_p2_q  <= href_p2_d;
      bit_p2_q   <= bit_p2_d;
      post_vs_q  <= post_vs_d;
      active_q   <= active_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign io.post_img_vsync = vsync_p2_q;
  assign io.post_img_href  = href_p2_q;
  assign io.post_img_bit   = bit_p2_q;
  assign io.frame_fg_count = cnt_q;
  assign io.frame_done     = done_q;

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Bench for bin_morph_3x3: streams small 8x6 frames as 3x3 windows and compares the
// output stream and frame statistics against a direct neighbourhood model.
module tb_bin_morph_3x3;
  localparam int CNT_W     = 20;
  localparam int IMG_HDISP = 640;
  localparam int IMG_VDISP = 480;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int NT = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfg_mode;
  logic       cfg_pad;

  bin_morph_3x3_if #(.CNT_W(CNT_W)) bus ();

  bin_morph_3x3 #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_mode (cfg_mode),
    .cfg_pad  (cfg_pad),
    .io       (bus)
  );

  always #5 clk = ~clk;

  bit img [H][W];
  bit exp_vs [NT];
  bit exp_hr [NT];
  bit exp_bit[NT];
  bit exp_fd [NT];
  int exp_cnt[NT];
  int tick = 0;
  int errors = 0;
  int checks = 0;
  bit last_vs = 1'b0;
  bit pending_live = 1'b0;
  int pending_cnt = 0;

  function automatic bit nb(int r, int c, bit pad);
    if (r < 0 || r >= H || c < 0 || c >= W) return pad;
    return img[r][c];
  endfunction

  // Expected output pixel straight from the neighbourhood definition.
  function automatic bit ref_pix(int r, int c, int mode, bit pad);
    bit all1 = 1'b1;
    bit any1 = 1'b0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        all1 &= nb(r + dr, c + dc, pad);
        any1 |= nb(r + dr, c + dc, pad);
      end
    case (mode)
      1:       return all1;
      2:       return any1;
      3:       return img[r][c] & ~all1;
      default: return img[r][c];
    endcase
  endfunction

  // Out-of-frame taps carry junk so only the padding logic decides them.
  function automatic logic tapv(bit hr, int r, int c);
    if (!hr || r < 0 || r >= H || c < 0 || c >= W) return 1'($urandom & 1);
    return img[r][c];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at tick %0d", tag, obs, expv, tick);
    end
  endtask

  task automatic drive(input bit vs, input bit hr, input int r, input int c,
                       input bit eb, input bit live);
    bus.matrix_img_vsync        = vs;
    bus.matrix_img_href         = hr;
    bus.matrix_top_edge_flag    = hr && (r == 0);
    bus.matrix_bottom_edge_flag = hr && (r == H - 1);
    bus.matrix_left_edge_flag   = hr && (c == 0);
    bus.matrix_right_edge_flag  = hr && (c == W - 1);
    bus.matrix_p11 = tapv(hr, r - 1, c - 1);
    bus.matrix_p12 = tapv(hr, r - 1, c);
    bus.matrix_p13 = tapv(hr, r - 1, c + 1);
    bus.matrix_p21 = tapv(hr, r,     c - 1);
    bus.matrix_p22 = tapv(hr, r,     c);
    bus.matrix_p23 = tapv(hr, r,     c + 1);
    bus.matrix_p31 = tapv(hr, r + 1, c - 1);
    bus.matrix_p32 = tapv(hr, r + 1, c);
    bus.matrix_p33 = tapv(hr, r + 1, c + 1);
    if (!vs && last_vs && pending_live) begin
      exp_fd[tick + 3]  = 1'b1;
      exp_cnt[tick + 3] = pending_cnt;
      pending_live      = 1'b0;
    end
    last_vs       = vs;
    exp_vs[tick]  = vs & live;
    exp_hr[tick]  = hr & live;
    exp_bit[tick] = hr & live & eb;
    @(posedge clk);
    tick++;
    #1;
    if (tick >= 2) begin
      check("post_img_vsync", 32'(bus.post_img_vsync), 32'(exp_vs[tick - 2]));
      check("post_img_href",  32'(bus.post_img_href),  32'(exp_hr[tick - 2]));
      check("post_img_bit",   32'(bus.post_img_bit),   32'(exp_bit[tick - 2]));
    end
    check("frame_done", 32'(bus.frame_done), 32'(exp_fd[tick]));
    if (exp_fd[tick]) check("frame_fg_count", 32'(bus.frame_fg_count), 32'(exp_cnt[tick]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vsync"}, 32'(bus.post_img_vsync), 32'd0);
    check({tag, "_href"},  32'(bus.post_img_href),  32'd0);
    check({tag, "_bit"},   32'(bus.post_img_bit),   32'd0);
    check({tag, "_done"},  32'(bus.frame_done),     32'd0);
    check({tag, "_count"}, 32'(bus.frame_fg_count), 32'd0);
  endtask

  // One frame: pre-rise idle, optional blank rise cycle, rows of W pixels with
  // 2-cycle href gaps. cfg is wrong before the rise and changed again mid-frame.
  task automatic send_frame(input int pre_idle, input bit lead, input int mode_first,
                            input int mode_mid, input bit pad, input int rst_row,
                            input int want);
    int cnt = 0;
    bit live = 1'b1;
    bit eb;
    cfg_mode = 2'(mode_first ^ 3);
    cfg_pad  = ~pad;
    for (int i = 0; i < pre_idle; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    cfg_mode = 2'(mode_first);
    cfg_pad  = pad;
    if (lead) drive(1'b1, 1'b0, 0, 0, 1'b0, live);
    for (int r = 0; r < H; r++) begin
      if (r == 3) begin
        cfg_mode = 2'(mode_mid);
        cfg_pad  = ~pad;
      end
      if (r == rst_row) begin
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid");
        if (tick >= 1) begin
          exp_vs[tick - 1]  = 1'b0;
          exp_hr[tick - 1]  = 1'b0;
          exp_bit[tick - 1] = 1'b0;
        end
        live = 1'b0;
      end
      for (int c = 0; c < W; c++) begin
        if (r == rst_row && c == 2) rst = 1'b0;
        eb = ref_pix(r, c, mode_first, pad);
        if (live) cnt += int'(eb);
        drive(1'b1, 1'b1, r, c, eb, live);
      end
      drive(1'b1, 1'b0, 0, 0, 1'b0, live);
      drive(1'b1, 1'b0, 0, 0, 1'b0, live);
    end
    pending_live = live;
    pending_cnt  = (want >= 0) ? want : cnt;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 1'($urandom & 1);
  endtask

  task automatic fill_const(input bit v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  initial begin
    $display("tb_bin_morph_3x3: nominal image %0dx%0d, bench image %0dx%0d",
             IMG_HDISP, IMG_VDISP, W, H);
    rst      = 1'b1;
    cfg_mode = 2'b00;
    cfg_pad  = 1'b0;
    bus.matrix_img_vsync = 1'b0;
    bus.matrix_img_href  = 1'b0;
    #2;
    check_all_zero("reset_state");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Pass-through of an alternating pattern.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 1'(c & 1);
    send_frame(3, 1'b1, 0, 2, 1'b0, -1, 24);

    // Erode of an all-ones frame with both pad values.
    fill_const(1'b1);
    send_frame(3, 1'b1, 1, 2, 1'b0, -1, 24);
    send_frame(3, 1'b1, 1, 0, 1'b1, -1, 48);

    // Dilate of a single foreground pixel at x=3, y=2.
    fill_const(1'b0);
    img[2][3] = 1'b1;
    send_frame(3, 1'b1, 2, 1, 1'b0, -1, 9);

    // Boundary of a solid 4x4 block.
    fill_const(1'b0);
    for (int r = 1; r <= 4; r++)
      for (int c = 2; c <= 5; c++) img[r][c] = 1'b1;
    send_frame(3, 1'b1, 3, 1, 1'b0, -1, 12);

    // Mid-frame mode change ignored, then back-to-back frame with mode set on the rise pixel.
    fill_random();
    send_frame(2, 1'b1, 1, 2, 1'b0, -1, -1);
    fill_random();
    send_frame(1, 1'b0, 2, 1, 1'b0, -1, -1);

    // Randomised frames.
    for (int k = 0; k < 4; k++) begin
      fill_random();
      send_frame(int'($urandom_range(1, 3)), 1'($urandom & 1), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom & 1), -1, -1);
    end

    // Reset during row 3, a clean frame, then a frame already in progress at release.
    fill_random();
    send_frame(3, 1'b1, 2, 1, 1'b0, 3, -1);
    fill_const(1'b1);
    send_frame(3, 1'b1, 2, 3, 1'b0, -1, 48);
    fill_random();
    send_frame(4, 1'b0, 1, 2, 1'b1, 0, -1);

    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
